// File: rtl/token_window_counter.sv
// Counts '1' tokens over back-to-back WINDOW-cycle windows.
// Each window count goes into a first-word-fall-through FIFO; drops when full are reported.
module token_window_counter #(
    parameter int unsigned WINDOW = 8,
    parameter int unsigned CNT_W  = $clog2(WINDOW + 1),
    parameter int unsigned DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             overflow,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned CYC_W = $clog2(WINDOW);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WINDOW - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic             win_end;
    logic [CNT_W-1:0] win_sum;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    always_comb begin
        win_end = (cyc_q == CYC_LAST);
        // acc never exceeds WINDOW-1 here, so the final sum fits CNT_W without wrapping
        win_sum = acc_q + CNT_W'(a);
        empty   = (occ_q == '0);
        full    = (occ_q == OCC_FULL);
        pop     = !empty && out_ready;
        // a simultaneous pop frees a slot, so a full FIFO still accepts the push
        push    = win_end && (!full || pop);
        drop    = win_end && full && !pop;
    end

    always_comb begin
        cyc_d = win_end ? '0 : cyc_q + CYC_W'(1);
        acc_d = win_end ? '0 : win_sum;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = win_sum;
        end
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        occ_d = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        overflow_d = overflow_q | drop;
        drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q      <= '0;
            acc_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cyc_q      <= cyc_d;
            acc_q      <= acc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            mem_q      <= mem_d;
        end
    end

    // Outputs follow occupancy directly, so an asynchronous reset clears them at once
    always_comb begin
        out_valid = !empty;
        out_count = empty ? '0 : mem_q[rd_ptr_q];
        overflow  = overflow_q;
        drop_cnt  = drop_cnt_q;
    end

endmodule

// File: tb/tb_token_window_counter.sv
// Bench for token_window_counter: directed scenarios plus randomized traffic,
// checked against a queue-based window/FIFO model.
module tb_token_window_counter;

    localparam int WINDOW = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             a;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             overflow;
    logic [7:0]       drop_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_cyc;
    int m_acc;
    int m_ovf;
    int m_drop;
    int m_q[$];

    token_window_counter #(
        .WINDOW(WINDOW),
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_count(out_count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_cyc  = 0;
        m_acc  = 0;
        m_ovf  = 0;
        m_drop = 0;
        m_q.delete();
    endtask

    task automatic model_edge(input int av, input int rv);
        int val;
        if (m_q.size() > 0 && rv != 0) void'(m_q.pop_front());
        val = m_acc + av;
        if (m_cyc == WINDOW - 1) begin
            if (m_q.size() < DEPTH) m_q.push_back(val);
            else begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
            m_acc = 0;
        end else begin
            m_acc = val;
        end
        m_cyc = (m_cyc + 1) % WINDOW;
    endtask

    function automatic int m_head();
        return (m_q.size() > 0) ? m_q[0] : 0;
    endfunction

    // Drive at a falling edge, let the rising edge happen, return at the next falling edge
    task automatic step(input int av, input int rv);
        a         = 1'(av);
        out_ready = 1'(rv);
        @(posedge clk);
        model_edge(av, rv);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        a         = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        a         = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", out_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_pattern();
        int p[8] = '{1, 1, 0, 0, 1, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL p1_idle[%0d]: got %b want 0", i, out_valid); end
            step(p[i], 1);
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL p1_valid: got %b want 1", out_valid); end
        checks++; if (out_count !== 4'd5) begin errors++; $display("FAIL p1_count: got %0d want 5", out_count); end
        step(0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL p1_one_cycle: got %b want 0", out_valid); end
    endtask

    task automatic test_full_ones();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, 1);
            if (i == 7 || i == 15) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ones_valid[%0d]: got %b want 1", i, out_valid); end
                checks++; if (out_count !== 4'b1000) begin errors++; $display("FAIL ones_count[%0d]: got %0d want 8", i, out_count); end
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 1);
            if (i == 0) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zeros_popped: got %b want 0", out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zeros_valid: got %b want 1", out_valid); end
        checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL zeros_count: got %0d want 0", out_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int w = 0; w < 5; w++) begin
            for (int i = 0; i < 8; i++) step(int'(i % 2 == 0), 0);
            if (w == 3) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b want 0", overflow); end
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL ovf_drop: got %0d want 1", drop_cnt); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_pop_valid[%0d]: got %b want 1", k, out_valid); end
            checks++; if (out_count !== 4'd4) begin errors++; $display("FAIL ovf_pop_count[%0d]: got %0d want 4", k, out_count); end
            step(0, 1);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 8; i++) begin
                if (w > 0) begin
                    checks++; if (out_count !== 4'd1 || out_valid !== 1'b1) begin
                        errors++; $display("FAIL hold_head[%0d.%0d]: got v=%b c=%0d want v=1 c=1", w, i, out_valid, out_count);
                    end
                end
                step(int'(i <= w), 0);
            end
        end
        for (int i = 0; i < 8; i++) step(int'(i < 5), int'(i == 7));
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL b2b_drop: got %0d want 0", drop_cnt); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b1 || out_count !== CNT_W'(k + 2)) begin
                errors++; $display("FAIL b2b_order[%0d]: got v=%b c=%0d want v=1 c=%0d", k, out_valid, out_count, k + 2);
            end
            step(0, 1);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5 * WINDOW; i++) step(1, 0);
        for (int i = 0; i < 3; i++) step(1, 0);
        checks++; if (out_valid !== 1'b1 || overflow !== 1'b1) begin
            errors++; $display("FAIL arst_pre: got v=%b ovf=%b want v=1 ovf=1", out_valid, overflow);
        end
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", out_valid); end
        checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", out_count); end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++; $display("FAIL arst_ovf: got ovf=%b drop=%0d want 0 0", overflow, drop_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_idle[%0d]: got %b want 0", i, out_valid); end
            step(0, 1);
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_win_valid: got %b want 1", out_valid); end
        checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL arst_win_count: got %0d want 0", out_count); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 300 * WINDOW; i++) step(int'($urandom_range(0, 1)), 0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow: got %b want 1", overflow); end
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop: got %0d want 255", drop_cnt); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b1 || out_count !== CNT_W'(m_head())) begin
                errors++; $display("FAIL sat_contents[%0d]: got v=%b c=%0d want v=1 c=%0d", k, out_valid, out_count, m_head());
            end
            step(0, 1);
        end
    endtask

    task automatic test_random();
        int thr;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            thr = (i < 400) ? 1 : 3;
            step(int'($urandom_range(0, 1)), int'($urandom_range(0, 3) < thr));
            checks++; if (out_valid !== (m_q.size() > 0) || out_count !== CNT_W'(m_head())) begin
                errors++; $display("FAIL rnd_out[%0d]: got v=%b c=%0d want v=%0d c=%0d", i, out_valid, out_count, m_q.size() > 0, m_head());
            end
            checks++; if (overflow !== 1'(m_ovf) || drop_cnt !== 8'(m_drop)) begin
                errors++; $display("FAIL rnd_ovf[%0d]: got ovf=%b drop=%0d want ovf=%0d drop=%0d", i, overflow, drop_cnt, m_ovf, m_drop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_full_ones();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
